// File: rtl/crack_controller_if.sv
// Generator / hash-core side channel of the crack controller.
// master = controller, slave = guess generators plus hash cores.
interface crack_controller_if #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned GUESS_W = 128
);
    logic                       gen_reset;
    logic [2:0]                 gen_charset;
    logic [4:0]                 gen_guesslen;
    logic [NUM_CH*GUESS_W-1:0]  gen_guess;
    logic                       gen_done;
    logic                       core_valid;
    logic [NUM_CH*GUESS_W-1:0]  core_hash;

    modport master (
        output gen_reset, gen_charset, gen_guesslen, core_valid,
        input  gen_guess, gen_done, core_hash
    );

    modport slave (
        input  gen_reset, gen_charset, gen_guesslen, core_valid,
        output gen_guess, gen_done, core_hash
    );
endinterface

// File: rtl/crack_controller.sv
// Brute-force search sequencer: walks guess lengths, feeds the hash cores and
// compares their delayed outputs against the target digest.
module crack_controller #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned HASH_LAT = 64,
    parameter int unsigned GUESS_W  = 128,
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic [2:0]          cfg_charset_i,
    input  logic [4:0]          cfg_min_len_i,
    input  logic [4:0]          cfg_max_len_i,
    input  logic [GUESS_W-1:0]  target_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                hit_o,
    output logic [GUESS_W-1:0]  hit_guess_o,
    output logic [CH_W-1:0]     hit_ch_o,
    crack_controller_if.master  gen_bus
);
    localparam int unsigned DW = $clog2(HASH_LAT + 1);

    typedef enum logic [2:0] {StIdle, StGenRst, StRun, StDrain, StFinish} state_e;

    state_e                    state_q;
    logic [4:0]                len_q, max_len_q;
    logic [2:0]                charset_q;
    logic [DW-1:0]             drain_cnt_q;
    logic                      busy_q, done_q, hit_q, gen_reset_q, core_valid_q;
    logic [GUESS_W-1:0]        hit_guess_q;
    logic [CH_W-1:0]           hit_ch_q;
    logic [HASH_LAT-1:0]       dl_valid_q;
    logic [NUM_CH*GUESS_W-1:0] dl_guess_q [HASH_LAT];

    logic                      start_acc;
    logic                      match;
    logic [CH_W-1:0]           match_ch;
    logic [GUESS_W-1:0]        match_guess;

    assign start_acc = start_i && (state_q == StIdle);

    // Guesses ride alongside the hash cores so each digest meets its own guess.
    always_ff @(posedge clk) begin
        if (reset || start_acc) begin
            dl_valid_q <= '0;
        end else begin
            dl_valid_q[0] <= core_valid_q;
            for (int k = 1; k < HASH_LAT; k++) dl_valid_q[k] <= dl_valid_q[k-1];
        end
        dl_guess_q[0] <= gen_bus.gen_guess;
        for (int k = 1; k < HASH_LAT; k++) dl_guess_q[k] <= dl_guess_q[k-1];
    end

    // Lowest matching lane wins.
    always_comb begin
        match       = 1'b0;
        match_ch    = '0;
        match_guess = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!match && dl_valid_q[HASH_LAT-1] &&
                gen_bus.core_hash[i*GUESS_W +: GUESS_W] == target_i) begin
                match       = 1'b1;
                match_ch    = CH_W'(i);
                match_guess = dl_guess_q[HASH_LAT-1][i*GUESS_W +: GUESS_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            len_q        <= '0;
            max_len_q    <= '0;
            charset_q    <= '0;
            drain_cnt_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            hit_q        <= 1'b0;
            hit_guess_q  <= '0;
            hit_ch_q     <= '0;
            gen_reset_q  <= 1'b0;
            core_valid_q <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            gen_reset_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    busy_q <= 1'b0;
                    if (start_i) begin
                        busy_q      <= 1'b1;
                        charset_q   <= cfg_charset_i;
                        len_q       <= cfg_min_len_i;
                        max_len_q   <= cfg_max_len_i;
                        hit_q       <= 1'b0;
                        hit_guess_q <= '0;
                        hit_ch_q    <= '0;
                        if (cfg_min_len_i == 5'd0 || cfg_min_len_i > cfg_max_len_i) begin
                            state_q <= StFinish;
                        end else begin
                            state_q     <= StGenRst;
                            gen_reset_q <= 1'b1;
                        end
                    end
                end
                StGenRst: begin
                    state_q      <= StRun;
                    core_valid_q <= 1'b1;
                end
                StRun, StDrain: begin
                    if (match) begin
                        hit_q        <= 1'b1;
                        hit_guess_q  <= match_guess;
                        hit_ch_q     <= match_ch;
                        core_valid_q <= 1'b0;
                        state_q      <= StFinish;
                    end else if (state_q == StRun) begin
                        if (gen_bus.gen_done) begin
                            core_valid_q <= 1'b0;
                            drain_cnt_q  <= DW'(HASH_LAT);
                            state_q      <= StDrain;
                        end
                    end else if (drain_cnt_q == DW'(1)) begin
                        if (len_q == max_len_q) begin
                            state_q <= StFinish;
                        end else begin
                            len_q       <= len_q + 5'd1;
                            gen_reset_q <= 1'b1;
                            state_q     <= StGenRst;
                        end
                    end else begin
                        drain_cnt_q <= drain_cnt_q - DW'(1);
                    end
                end
                StFinish: begin
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o               = busy_q;
    assign done_o               = done_q;
    assign hit_o                = hit_q;
    assign hit_guess_o          = hit_guess_q;
    assign hit_ch_o             = hit_ch_q;
    assign gen_bus.gen_reset    = gen_reset_q;
    assign gen_bus.gen_charset  = charset_q;
    assign gen_bus.gen_guesslen = len_q;
    assign gen_bus.core_valid   = core_valid_q;
endmodule

// File: tb/tb_crack_controller.sv
// Directed bench: behavioural generator (6 guesses per length) and a 4-cycle
// hash pipe in which lane 3 deliberately collides with lane 1.
module tb_crack_controller;
    localparam int unsigned NCH = 4;
    localparam int unsigned LAT = 4;
    localparam int unsigned GW  = 128;
    localparam logic [GW-1:0] KEY = {4{32'hC001_D00D}};

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    cfg_charset = '0;
    logic [4:0]    cfg_min_len = '0;
    logic [4:0]    cfg_max_len = '0;
    logic [GW-1:0] target = '0;
    logic          busy, done, hit;
    logic [GW-1:0] hit_guess;
    logic [1:0]    hit_ch;

    crack_controller_if #(.NUM_CH(NCH), .GUESS_W(GW)) gen_bus ();

    crack_controller #(.NUM_CH(NCH), .HASH_LAT(LAT), .GUESS_W(GW)) dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start),
        .cfg_charset_i (cfg_charset),
        .cfg_min_len_i (cfg_min_len),
        .cfg_max_len_i (cfg_max_len),
        .target_i      (target),
        .busy_o        (busy),
        .done_o        (done),
        .hit_o         (hit),
        .hit_guess_o   (hit_guess),
        .hit_ch_o      (hit_ch),
        .gen_bus       (gen_bus)
    );

    always #5 clk = ~clk;

    function automatic logic [GW-1:0] gf(input int len, input int cnt, input int lane);
        return {96'h0123_4567_89AB_CDEF_0F1E_2D3C, 8'(len), 8'(cnt), 8'(lane), 8'h5A};
    endfunction

    function automatic logic [GW-1:0] hf(input logic [GW-1:0] g);
        logic [GW-1:0] h;
        h = g;
        if (h[15:8] == 8'd3) h[15:8] = 8'd1;
        return {h[63:0], h[127:64]} ^ KEY;
    endfunction

    // Generator model
    int cnt;
    always @(posedge clk) begin
        if (reset || gen_bus.gen_reset) cnt <= 0;
        else if (gen_bus.core_valid)    cnt <= cnt + 1;
    end
    assign gen_bus.gen_done  = (cnt == 5);
    assign gen_bus.gen_guess = {gf(int'(gen_bus.gen_guesslen), cnt, 3),
                                gf(int'(gen_bus.gen_guesslen), cnt, 2),
                                gf(int'(gen_bus.gen_guesslen), cnt, 1),
                                gf(int'(gen_bus.gen_guesslen), cnt, 0)};

    // Hash-core model
    logic [NCH*GW-1:0] hp [LAT];
    always @(posedge clk) begin
        for (int l = 0; l < NCH; l++) hp[0][l*GW +: GW] <= hf(gen_bus.gen_guess[l*GW +: GW]);
        for (int k = 1; k < LAT; k++) hp[k] <= hp[k-1];
    end
    assign gen_bus.core_hash = hp[LAT-1];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [GW-1:0] obs, input logic [GW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int n_rst, t_hit, t_done, t_gd, gap;
    int lens [4];
    logic cs_ok;

    // t counts cycles after the accepted start edge, sampled at negedge.
    task automatic run_search(input logic [4:0] mn, input logic [4:0] mx,
                              input logic [2:0] cs, input logic [GW-1:0] tgt,
                              input int spur_at);
        n_rst = 0; t_hit = -1; t_done = -1; t_gd = -1; gap = -1; cs_ok = 1'b1;
        for (int i = 0; i < 4; i++) lens[i] = 0;
        @(negedge clk);
        start = 1'b1; cfg_min_len = mn; cfg_max_len = mx; cfg_charset = cs; target = tgt;
        @(negedge clk);
        start = 1'b0;
        for (int t = 1; t <= 100 && t_done < 0; t++) begin
            if (t == spur_at) begin
                start = 1'b1; cfg_min_len = 5'd1; cfg_max_len = 5'd1; cfg_charset = 3'd7;
            end else begin
                start = 1'b0;
            end
            if (gen_bus.gen_reset) begin
                if (n_rst < 4) lens[n_rst] = int'(gen_bus.gen_guesslen);
                n_rst++;
                if (t_gd >= 0 && gap < 0) gap = t - t_gd;
            end
            if (gen_bus.core_valid && gen_bus.gen_done && t_gd < 0) t_gd = t;
            if (hit && t_hit < 0) t_hit = t;
            if (busy && gen_bus.gen_charset != cs) cs_ok = 1'b0;
            if (done) t_done = t;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hit", hit, 0);
        check("rst_hit_ch", hit_ch, 0);
        check("rst_hit_guess", hit_guess, 0);
        check("rst_gen_reset", gen_bus.gen_reset, 0);
        check("rst_core_valid", gen_bus.core_valid, 0);
        reset = 1'b0;

        // Single length, lane 2 matches on RUN cycle 5
        run_search(5'd2, 5'd2, 3'd5, hf(gf(2, 4, 2)), 0);
        check("t1_t_hit", t_hit, 11);
        check("t1_hit_ch", hit_ch, 2);
        check("t1_hit_guess", hit_guess, gf(2, 4, 2));
        check("t1_t_done", t_done, 12);
        check("t1_n_rst", n_rst, 1);
        check("t1_len0", lens[0], 2);
        check("t1_charset", cs_ok, 1);
        check("t1_busy_after", busy, 0);
        check("t1_hit_held", hit, 1);

        // Three lengths, no match
        run_search(5'd1, 5'd3, 3'd3, '0, 0);
        check("t2_n_rst", n_rst, 3);
        check("t2_len0", lens[0], 1);
        check("t2_len1", lens[1], 2);
        check("t2_len2", lens[2], 3);
        check("t2_gap", gap, 5);
        check("t2_t_done", t_done, 35);
        check("t2_t_hit", t_hit, -1);
        check("t2_hit", hit, 0);

        // Lanes 1 and 3 collide
        run_search(5'd3, 5'd3, 3'd1, hf(gf(3, 0, 1)), 0);
        check("t3_hit_ch", hit_ch, 1);
        check("t3_hit_guess", hit_guess, gf(3, 0, 1));
        check("t3_t_hit", t_hit, 7);
        check("t3_t_done", t_done, 8);

        // Final guess of max length, seen on the last drain cycle
        run_search(5'd1, 5'd2, 3'd2, hf(gf(2, 5, 0)), 0);
        check("t4_t_hit", t_hit, 23);
        check("t4_t_done", t_done, 24);
        check("t4_n_rst", n_rst, 2);
        check("t4_hit_ch", hit_ch, 0);
        check("t4_hit_guess", hit_guess, gf(2, 5, 0));

        // Degenerate ranges
        run_search(5'd0, 5'd3, 3'd0, hf(gf(1, 0, 0)), 0);
        check("t5a_t_done", t_done, 2);
        check("t5a_hit", hit, 0);
        check("t5a_hit_guess", hit_guess, 0);
        check("t5a_n_rst", n_rst, 0);
        run_search(5'd5, 5'd3, 3'd0, hf(gf(1, 0, 0)), 0);
        check("t5b_t_done", t_done, 2);
        check("t5b_n_rst", n_rst, 0);

        // Reset mid-RUN, then restart with a spurious start while busy
        @(negedge clk);
        start = 1'b1; cfg_min_len = 5'd2; cfg_max_len = 5'd3; target = hf(gf(2, 5, 0));
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_in_run", gen_bus.core_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_hit", hit, 0);
        check("t6_core_valid", gen_bus.core_valid, 0);
        check("t6_gen_reset", gen_bus.gen_reset, 0);
        run_search(5'd2, 5'd3, 3'd4, hf(gf(2, 2, 2)), 3);
        check("t6_len0", lens[0], 2);
        check("t6_n_rst", n_rst, 1);
        check("t6_t_hit", t_hit, 9);
        check("t6_t_done", t_done, 10);
        check("t6_hit_guess", hit_guess, gf(2, 2, 2));
        check("t6_charset", cs_ok, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/crack_controller.md
CRACK_CONTROLLER -- requirements
Module: crack_controller

Interface
REQ-001 Parameter NUM_CH, default 4, number of parallel guess/hash lanes (1..16).
REQ-002 Parameter HASH_LAT, default 64, fixed hash-core latency in cycles (>=1).
REQ-003 Parameter GUESS_W, default 128, guess and hash word width in bits.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to begin a search; sampled only in IDLE.
REQ-007 cfg_charset  input  3  charset code, latched on accepted start.
REQ-008 cfg_min_len / cfg_max_len  input  5 each  first and last guess length, latched on accepted start.
REQ-009 target  input  GUESS_W  digest to match; held stable by the user while busy.
REQ-010 busy  output  1  high from the cycle after an accepted start until done.
REQ-011 done  output  1  one-cycle pulse at search end.
REQ-012 hit  output  1  high when the last search found a match; held until the next accepted start.
REQ-013 hit_guess  output  GUESS_W  matching guess; valid while hit=1.
REQ-014 hit_ch  output  clog2(NUM_CH) (min 1)  lane index of the match.
REQ-015 gen_reset  output  1  one-cycle reset to the guess generators.
REQ-016 gen_charset / gen_guesslen  output  3 / 5  generator configuration.
REQ-017 gen_guess  input  NUM_CH*GUESS_W  current guess per lane, lane 0 in LSBs.
REQ-018 gen_done  input  1  generators are presenting their final guess for the current length.
REQ-019 core_valid  output  1  gen_guess is valid and is fed to the hash cores this cycle.
REQ-020 core_hash  input  NUM_CH*GUESS_W  hash-core outputs, lane 0 in LSBs.

Function
REQ-021 States: IDLE, GEN_RST, RUN, DRAIN, FINISH.
REQ-022 IDLE + start: latch cfg_*; len<=cfg_min_len. If cfg_min_len==0 or cfg_min_len>cfg_max_len, go to FINISH with hit=0; otherwise go to GEN_RST.
REQ-023 GEN_RST: gen_reset=1 for exactly one cycle, gen_guesslen=len; next state RUN.
REQ-024 RUN: core_valid=1 every cycle. The cycle with gen_done=1 still issues its guess, then moves to DRAIN with drain_cnt=HASH_LAT.
REQ-025 DRAIN: core_valid=0; drain_cnt decrements each cycle. At drain_cnt==1: if len==max_len, go to FINISH; otherwise len<=len+1 and go to GEN_RST.
REQ-026 Delay line: per lane, a HASH_LAT-deep shift register of {core_valid, gen_guess} aligns each guess with its core_hash output.
REQ-027 Compare: a lane matches when the delayed valid=1 and core_hash[lane]==target across all GUESS_W bits.
REQ-028 Any match in RUN or DRAIN: capture hit=1, hit_guess, hit_ch, then go to FINISH next cycle; the remaining search is aborted.
REQ-029 Simultaneous matches in several lanes: the lowest lane index wins.
REQ-030 A match on the final DRAIN cycle takes priority over the end-of-length transition.
REQ-031 FINISH: done=1 for one cycle, busy=0 from the following cycle, then return to IDLE.
REQ-032 start while not in IDLE is ignored.
REQ-033 An accepted start clears hit, hit_guess and hit_ch to 0 in the same cycle it is accepted.
REQ-034 gen_charset and gen_guesslen hold their latched values from start until the next accepted start.
REQ-035 Latency: start to gen_reset is 1 cycle. gen_done to next gen_reset is HASH_LAT+1 cycles.

Reset
REQ-036 reset forces IDLE and sets busy, done, hit, gen_reset and core_valid to 0.
REQ-037 reset clears hit_guess, hit_ch, len, drain_cnt and all delay-line valid bits.
REQ-038 reset mid-search aborts the search with no done pulse; in-flight delay-line entries are discarded.

Verification
REQ-039 NUM_CH=4, HASH_LAT=4, min=max=2, target=hash of a guess on lane 2 at RUN cycle 5 -> hit=1, hit_ch=2, correct hit_guess, done pulses 1 cycle later, then no further gen_reset.
REQ-040 min=1, max=3, target never matches -> three gen_reset pulses with gen_guesslen 1,2,3; DRAIN of 4 cycles each; done=1 with hit=0.
REQ-041 Lanes 1 and 3 match in the same cycle -> hit_ch=1.
REQ-042 Match on the last guess of max_len, seen on the final DRAIN cycle -> hit=1, done pulses, no extra GEN_RST.
REQ-043 min=0, or min=5 with max=3 -> done pulses 2 cycles after start, hit=0, gen_reset never asserted.
REQ-044 reset in RUN, then a new start -> no stale hit; the search restarts at cfg_min_len; start pulses while busy are ignored.
